// File: rtl/shreg256_serial_ctrl.sv
// shreg256_serial_ctrl
// Sequencer in front of the wide right-shift register. It loads the register
// one word per handshake, then shifts it right one bit per accepted serial
// transfer. Each shift exposes the next operand bit on reg_lsb, LSB first.
module shreg256_serial_ctrl #(
    parameter int WORDS = 8,
    parameter int W     = 32,
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_shift,
    input  logic [W-1:0]     din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             reg_lsb,
    output logic [W-1:0]     regin,
    output logic             we,
    output logic             sel_rs,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             busy,
    output logic             done
);

    localparam int               WC_W       = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] TOTAL_BITS = CNT_W'(WORDS * W);
    localparam logic [WC_W-1:0]  LAST_WORD  = WC_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WC_W-1:0]  word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] n_cap_q, n_cap_d;

    logic word_acc;
    logic bit_acc;

    // Transfer qualifiers: a word or bit moves when the bus handshake completes
    always_comb begin
        word_acc = (state_q == LOAD)  && din_valid;
        bit_acc  = (state_q == SHIFT) && bit_ready;
    end

    // State, counters and captured shift count; reset abandons any operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
            n_cap_q    <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            n_cap_q    <= n_cap_d;
        end
    end

    // Next-state and counter updates
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        n_cap_d    = n_cap_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Counts beyond the register width saturate; the register is empty by then
                    n_cap_d    = (n_shift > TOTAL_BITS) ? TOTAL_BITS : n_shift;
                    word_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (word_acc) begin
                    word_cnt_d = word_cnt_q + WC_W'(1);
                    if (word_cnt_q == LAST_WORD) begin
                        state_d = (n_cap_q != '0) ? SHIFT : DONE;
                    end
                end
            end
            SHIFT: begin
                if (bit_acc) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == n_cap_q - CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register controls and handshake outputs, decoded from state and inputs
    always_comb begin
        regin     = din;
        din_ready = (state_q == LOAD);
        bit_valid = (state_q == SHIFT);
        bit_out   = (state_q == SHIFT) && reg_lsb;
        sel_rs    = (state_q == SHIFT);
        we        = word_acc || bit_acc;
        busy      = (state_q == LOAD) || (state_q == SHIFT);
        done      = (state_q == DONE);
    end

endmodule

// File: tb/tb_shreg256_serial_ctrl.sv
// tb_shreg256_serial_ctrl
// Drives operands through the controller into a behavioural model of the
// shift register. Each expected serial bit is queued when an operation starts
// and checked when the controller hands that bit downstream.
module tb_shreg256_serial_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [8:0]  n_shift;
    logic [31:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        reg_lsb;
    logic [31:0] regin;
    logic        we;
    logic        sel_rs;
    logic        bit_out;
    logic        bit_valid;
    logic        bit_ready;
    logic        busy;
    logic        done;

    logic [255:0] shreg;
    logic         expQ[$];
    int           checkCount;
    int           passCount;

    shreg256_serial_ctrl #(.WORDS(8), .W(32), .CNT_W(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n_shift   (n_shift),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .reg_lsb   (reg_lsb),
        .regin     (regin),
        .we        (we),
        .sel_rs    (sel_rs),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .busy      (busy),
        .done      (done)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shift register: words enter at the top, bits leave at bit 0
    always @(posedge clk) begin
        if (we) begin
            if (sel_rs) shreg <= {1'b0, shreg[255:1]};
            else        shreg <= {regin, shreg[255:32]};
        end
    end
    assign reg_lsb = shreg[0];

    // Hard stop in case the stimulus itself gets stuck
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single point of comparison
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Run one operation; abortBits > 0 leaves mid-SHIFT after that many bits
    task automatic applyStimulus(input logic [8:0] n, input logic [255:0] operand,
                                 input bit dinStall, input bit bitStall,
                                 input bit pokeStart, input int expDone,
                                 input int abortBits);
        int  nCap;
        int  wordIdx;
        int  bitsDone;
        int  stallCnt;
        int  weCount;
        int  lastXfer;
        int  doneCycle;
        bit  doneSeen;
        bit  aborted;
        logic expBit;

        nCap = (n > 9'd256) ? 256 : int'(n);
        for (int i = 0; i < nCap; i++) expQ.push_back(operand[i]);
        wordIdx = 0; bitsDone = 0; stallCnt = 0; weCount = 0;
        lastXfer = 0; doneCycle = 0; doneSeen = 0; aborted = 0;

        start = 1'b1;
        n_shift = n;
        @(negedge clk);
        checkOutput("idle_ready", {31'd0, din_ready}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        n_shift = ~n;

        for (int cyc = 1; cyc < 3000 && !doneSeen && !aborted; cyc++) begin
            din       = (wordIdx < 8) ? operand[wordIdx*32 +: 32] : 32'hDEAD_BEEF;
            din_valid = dinStall ? (cyc % 2 == 1) : 1'b1;
            bit_ready = bitStall ? (stallCnt >= 3) : 1'b1;
            start     = pokeStart && (cyc == 3 || cyc == 10 || cyc == 13);
            @(negedge clk);
            if (we) weCount++;
            if (done) begin
                doneSeen  = 1;
                doneCycle = cyc;
            end
            if (din_ready) begin
                checkOutput("load_sel", {31'd0, sel_rs}, 32'd0);
                checkOutput("load_we", {31'd0, we}, {31'd0, din_valid});
                if (din_valid) begin
                    checkOutput("regin", regin, din);
                    wordIdx++;
                    lastXfer = cyc;
                end
            end
            if (bit_valid) begin
                checkOutput("shift_sel", {31'd0, sel_rs}, 32'd1);
                checkOutput("shift_we", {31'd0, we}, {31'd0, bit_ready});
                if (expQ.size() == 0) begin
                    checkOutput("sb_underflow", 32'd1, 32'd0);
                end else if (bit_ready) begin
                    expBit = expQ.pop_front();
                    checkOutput("bit", {31'd0, bit_out}, {31'd0, expBit});
                    bitsDone++;
                    stallCnt = 0;
                    lastXfer = cyc;
                end else begin
                    checkOutput("bit_hold", {31'd0, bit_out}, {31'd0, expQ[0]});
                    stallCnt++;
                end
            end
            @(posedge clk); #1;
            if (abortBits > 0 && bitsDone == abortBits) aborted = 1;
        end
        start = 1'b0;
        din_valid = 1'b0;

        if (!aborted) begin
            checkOutput("done_seen", {31'd0, doneSeen}, 32'd1);
            checkOutput("done_after_last", doneCycle, lastXfer + 1);
            if (expDone > 0) checkOutput("done_cycle", doneCycle, expDone);
            checkOutput("words", wordIdx, 8);
            checkOutput("bits", bitsDone, nCap);
            checkOutput("we_count", weCount, 8 + nCap);
            checkOutput("sb_empty", expQ.size(), 0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                checkOutput("post_busy", {31'd0, busy}, 32'd0);
                checkOutput("post_done", {31'd0, done}, 32'd0);
                @(posedge clk); #1;
            end
        end
    endtask

    // Every controller output must be low while idle or in reset
    task automatic checkAllLow(input string tag);
        checkOutput({tag, "_din_ready"}, {31'd0, din_ready}, 32'd0);
        checkOutput({tag, "_we"},        {31'd0, we},        32'd0);
        checkOutput({tag, "_sel_rs"},    {31'd0, sel_rs},    32'd0);
        checkOutput({tag, "_bit_valid"}, {31'd0, bit_valid}, 32'd0);
        checkOutput({tag, "_bit_out"},   {31'd0, bit_out},   32'd0);
        checkOutput({tag, "_busy"},      {31'd0, busy},      32'd0);
        checkOutput({tag, "_done"},      {31'd0, done},      32'd0);
    endtask

    // Test sequence
    initial begin
        logic [255:0] op;
        checkCount = 0;
        passCount  = 0;
        rst_n = 1'b0; start = 1'b0; n_shift = '0; din = 32'h1234_5678;
        din_valid = 1'b0; bit_ready = 1'b0;
        shreg = {8{32'hA5A5_5A5A}};

        repeat (2) @(posedge clk);
        #1;
        checkAllLow("reset");
        checkOutput("reset_regin", regin, 32'h1234_5678);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] basic");
        applyStimulus(9'd4, 256'hD, 0, 0, 0, 13, 0);

        $display("[TB] backpressure");
        applyStimulus(9'd4, 256'hD, 1, 1, 0, 0, 0);

        $display("[TB] zero count");
        for (int i = 0; i < 8; i++) op[i*32 +: 32] = $urandom;
        applyStimulus(9'd0, op, 0, 0, 0, 9, 0);

        $display("[TB] saturation");
        applyStimulus(9'd300, {256{1'b1}}, 0, 0, 0, 265, 0);

        $display("[TB] full width ordering");
        applyStimulus(9'd256, {32'h0000_0001, 192'd0, 32'h8000_0000}, 0, 0, 0, 265, 0);

        $display("[TB] reset mid-shift");
        for (int i = 0; i < 8; i++) op[i*32 +: 32] = $urandom;
        applyStimulus(9'd256, op, 0, 0, 0, 0, 5);
        rst_n = 1'b0;
        #1;
        checkAllLow("midreset");
        expQ.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) op[i*32 +: 32] = $urandom;
        applyStimulus(9'd20, op, 0, 0, 0, 29, 0);

        $display("[TB] start while busy");
        applyStimulus(9'd4, 256'hD, 0, 0, 1, 13, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
